// File: rtl/jstk_spi_responder_if.sv
// Pin-level SPI link between the joystick master and the PmodJSTK responder.
interface jstk_spi_responder_if;
    logic ss;
    logic sclk;
    logic mosi;
    logic miso;

    modport master (output ss, output sclk, output mosi, input miso);
    modport slave  (input ss, input sclk, input mosi, output miso);
endinterface

// File: rtl/jstk_spi_responder.sv
// PmodJSTK-side SPI responder: serves a 5-byte position/button frame on MISO and captures
// the LED command byte. All pins are oversampled in the clk domain; no SCLK-clocked logic.
module jstk_spi_responder #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    jstk_spi_responder_if.slave         spi,
    input  logic [9:0]                  x_pos,
    input  logic [9:0]                  y_pos,
    input  logic [2:0]                  btn,
    output logic [1:0]                  led,
    output logic                        frame_done,
    output logic                        frame_err
);

    localparam int unsigned NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [1:0] {StIdle, StActive, StOverrun} state_e;

    logic [NS-1:0] ss_sync, sclk_sync, mosi_sync, vld_sync;
    logic          ss_d1, sclk_d1;
    logic          ss_s, sclk_s, mosi_s;
    logic          ss_fall, ss_rise, sclk_rise, sclk_fall;

    state_e        state_q, state_d;
    logic [5:0]    cnt_q, cnt_d;
    logic [39:0]   tx_q, tx_d;
    logic [7:0]    rx_q, rx_d;
    logic          miso_q, miso_d;
    logic [1:0]    led_q, led_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          armed_q, armed_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            ss_sync   <= '1;
            sclk_sync <= '0;
            mosi_sync <= '0;
            vld_sync  <= '0;
            ss_d1     <= 1'b1;
            sclk_d1   <= 1'b0;
        end else begin
            ss_sync   <= {ss_sync[NS-2:0], spi.ss};
            sclk_sync <= {sclk_sync[NS-2:0], spi.sclk};
            mosi_sync <= {mosi_sync[NS-2:0], spi.mosi};
            vld_sync  <= {vld_sync[NS-2:0], 1'b1};
            ss_d1     <= ss_s;
            sclk_d1   <= sclk_s;
        end
    end

    assign ss_s      = ss_sync[NS-1];
    assign sclk_s    = sclk_sync[NS-1];
    assign mosi_s    = mosi_sync[NS-1];
    assign ss_fall   = ss_d1 & ~ss_s;
    assign ss_rise   = ~ss_d1 & ss_s;
    assign sclk_rise = ~sclk_d1 & sclk_s;
    assign sclk_fall = sclk_d1 & ~sclk_s;

    // Only arm once a genuinely sampled high SS has reached ss_s, so a pin that is
    // already low when reset releases never starts a frame mid-way.
    assign armed_d = armed_q | (vld_sync[NS-1] & ss_s);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        miso_d  = miso_q;
        led_d   = led_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            StIdle: begin
                miso_d = 1'b0;
                if (armed_q && ss_fall) begin
                    tx_d    = {x_pos[7:0], 6'b0, x_pos[9:8], y_pos[7:0], 6'b0, y_pos[9:8],
                               5'b0, btn};
                    miso_d  = x_pos[7];
                    cnt_d   = 6'd0;
                    rx_d    = 8'd0;
                    state_d = StActive;
                end
            end
            StActive, StOverrun: begin
                if (ss_rise) begin
                    if (cnt_q == 6'd40) begin
                        done_d = 1'b1;
                        if (rx_q[7:2] == 6'b100000) led_d = rx_q[1:0];
                    end else begin
                        err_d = 1'b1;
                    end
                    miso_d  = 1'b0;
                    state_d = StIdle;
                end else if (state_q == StOverrun) begin
                    miso_d = 1'b0;
                end else if (sclk_rise) begin
                    if (cnt_q < 6'd8) rx_d = {rx_q[6:0], mosi_s};
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd39) begin
                        miso_d  = 1'b0;
                        state_d = StOverrun;
                    end
                end else if (sclk_fall) begin
                    tx_d   = {tx_q[38:0], 1'b0};
                    miso_d = tx_q[38];
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 6'd0;
            tx_q    <= 40'd0;
            rx_q    <= 8'd0;
            miso_q  <= 1'b0;
            led_q   <= 2'b00;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            miso_q  <= miso_d;
            led_q   <= led_d;
            done_q  <= done_d;
            err_q   <= err_d;
            armed_q <= armed_d;
        end
    end

    assign spi.miso   = miso_q;
    assign led        = led_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;

endmodule

// File: doc/jstk_spi_responder.md
# jstk_spi_responder

SPI responder that models the PmodJSTK end of the joystick link, so the joystick interface can be exercised in simulation and on board without the physical Pmod. It sits opposite the SPI master: it receives SS/SCLK/MOSI, returns a 5-byte position/button frame on MISO, and captures the LED command byte the master sends. All pin inputs are synchronised into the CLK domain and processed there; the block contains no SCLK-clocked logic.

## Interface
- SYNC_STAGES, 2: flip-flop stages on each of ss, sclk, mosi (minimum 2).
- CLK  in  1  system clock (100 MHz on board).
- RST  in  1  synchronous, active-high reset.
- ss  in  1  slave select from master, active low.
- sclk  in  1  SPI clock from master, mode 0 (idle low).
- mosi  in  1  master data out.
- miso  out  1  responder data out.
- x_pos  in  10  joystick X value to report.
- y_pos  in  10  joystick Y value to report.
- btn  in  3  button states to report ({btn2, btn1, trigger/joystick}).
- led  out  2  LED bits from the last valid command byte.
- frame_done  out  1  one-cycle pulse: complete 40-bit frame ended.
- frame_err  out  1  one-cycle pulse: frame ended with other than 40 bits.

## Operation
- Reset values: miso=0, led=2'b00, frame_done=0, frame_err=0, state IDLE, bit counter 0. Synchroniser flops reset to idle levels (ss=1, sclk=0, mosi=0).
- Synchronised signals ss_s, sclk_s, mosi_s; edge detect against one further registered copy.
- Frame order, MSB first per byte: B0={x_pos[7:0]}, B1={6'b0,x_pos[9:8]}, B2={y_pos[7:0]}, B3={6'b0,y_pos[9:8]}, B4={5'b0,btn}. On the master this lands as DOUT[39:32]=B0 … DOUT[7:0]=B4.
- States:
  - IDLE: miso=0. On ss_s falling edge: snapshot {B0..B4} into 40-bit tx shift register, drive miso=B0[7], clear counter and rx register, go ACTIVE.
  - ACTIVE: sclk_s rising: shift mosi_s into 8-bit rx register (first byte only, counter<8), increment counter. sclk_s falling: shift tx register left, miso=new MSB (0 fill). On reaching 40: go OVERRUN.
  - OVERRUN: further sclk edges ignored, miso=0.
  - In ACTIVE or OVERRUN, ss_s rising edge: if counter==40, pulse frame_done, and if rx[7:2]==6'b100000 load led<=rx[1:0]; otherwise pulse frame_err, led unchanged. Return to IDLE.
- After RST deasserts while ss_s is low: remain IDLE, ignore sclk, until ss_s has been seen high and then falls (no mid-frame start).
- x_pos/y_pos/btn changes during a frame do not affect the frame in flight.
- Counter width 6 bits; saturates at 40, never wraps.

## Timing
- Pin-to-event latency: SYNC_STAGES+1 CLK cycles for any ss/sclk/mosi edge.
- miso valid within SYNC_STAGES+2 CLK cycles after ss falling or sclk falling at the pin.
- Requirement on master: each SCLK half-period and SS-low-to-first-SCLK-rising ≥ SYNC_STAGES+4 CLK cycles (satisfied by the ~66.7 kHz joystick SCLK at 100 MHz).
- Same-cycle ss_s rising and sclk_s edge: ss rising wins; sclk edge discarded.
- Same-cycle ss_s falling and sclk_s rising: frame starts, sclk edge discarded (counter stays 0).
- frame_done/frame_err: exactly one CLK cycle, SYNC_STAGES+1 cycles after SS rising at the pin; led updates the same cycle as frame_done.
- RST wins over all events in the same cycle.

## Test plan
- x_pos=10'h2A5, y_pos=10'h13C, btn=3'b101, master sends 8'h83 then 4×8'h00 → master captures 40'hA5_02_3C_01_05; frame_done one pulse; led=2'b11.
- Cmd byte 8'h41 (bad header) in full frame → frame_done pulses, led holds previous 2'b11, frame_err stays 0.
- SS raised after 17 bits → frame_err one pulse, frame_done 0, led unchanged, next full frame reports correctly.
- 48 SCLK cycles in one SS window → bits 41–48 on miso read 0; frame_done pulses at SS rise.
- x_pos changed from 10'h000 to 10'h3FF mid-frame → current frame returns B0=8'h00, B1=8'h00; following frame returns 8'hFF, 8'h03.
- RST asserted at bit 20 with SS held low → miso=0, led=2'b00, no pulses; SCLK ignored until SS rises and falls again, then full frame correct.
